// File: rtl/snoop_sched_pkg.sv
// ============================================================================
// snoop_sched_pkg : shared types and constants for the snoop-bus scheduler
// Rev 1.0
// ============================================================================
`default_nettype none

package snoop_sched_pkg;

  localparam int NUM_CPUS             = 4;
  localparam int SNOOP_SCHED_MAX_HOLD = 64;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    HOLD    = 2'd2,
    RELEASE = 2'd3
  } sched_state_t;

  // Index width that stays legal for a single requester.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/snoop_sched_if.sv
// ============================================================================
// snoop_sched_if : request/busy handshake and grant bus of the snoop scheduler
// Rev 1.0
// ============================================================================
`default_nettype none

interface snoop_sched_if #(
  parameter int NUM_REQ = snoop_sched_pkg::NUM_CPUS
) ();

  localparam int IDW = snoop_sched_pkg::idx_w(NUM_REQ);

  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] busy;
  logic [NUM_REQ-1:0] gnt;
  logic [IDW-1:0]     gnt_id;
  logic               gnt_valid;
  logic               timeout_err;

  // Cache-controller side
  modport master (
    output req, busy,
    input  gnt, gnt_id, gnt_valid, timeout_err
  );

  // Scheduler side
  modport slave (
    input  req, busy,
    output gnt, gnt_id, gnt_valid, timeout_err
  );

endinterface

`default_nettype wire

// File: rtl/snoop_sched_rr_pick.sv
// ============================================================================
// rr_pick : combinational rotating-priority picker, first set request above last
// Rev 1.0
// ============================================================================
`default_nettype none

module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDW     = 2
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDW-1:0]     last_i,
  output logic [NUM_REQ-1:0] onehot_o,
  output logic [IDW-1:0]     idx_o,
  output logic               any_o
);

  logic [IDW-1:0] w_k;

  always_comb begin
    onehot_o = '0;
    idx_o    = '0;
    any_o    = 1'b0;
    w_k      = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      w_k = IDW'((int'(last_i) + i) % NUM_REQ);
      if (!any_o && req_i[w_k]) begin
        any_o         = 1'b1;
        idx_o         = w_k;
        onehot_o[w_k] = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/snoop_sched.sv
// ============================================================================
// snoop_sched : round-robin snoop-bus scheduler, one held one-hot grant at a time
// Optional grant-hold timeout: define SNOOP_SCHED_TIMEOUT_EN.   Rev 1.0
// ============================================================================
`default_nettype none

module snoop_sched
  import snoop_sched_pkg::*;
#(
  parameter int NUM_REQ  = NUM_CPUS,
  parameter int MAX_HOLD = SNOOP_SCHED_MAX_HOLD
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  snoop_sched_if.slave  bus
);

  localparam int IDW = idx_w(NUM_REQ);

  sched_state_t       state_q, state_d;
  logic [IDW-1:0]     last_q, last_d;
  logic [IDW-1:0]     win_q, win_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic               valid_q, valid_d;
  logic               w_rel;

  logic [NUM_REQ-1:0] w_pick_oh;
  logic [IDW-1:0]     w_pick_idx;
  logic               w_pick_any;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDW     (IDW)
  ) u_rr_pick (
    .req_i    (bus.req),
    .last_i   (last_q),
    .onehot_o (w_pick_oh),
    .idx_o    (w_pick_idx),
    .any_o    (w_pick_any)
  );

`ifdef SNOOP_SCHED_TIMEOUT_EN
  localparam int CNT_W = (idx_w(MAX_HOLD) + 1 > 8) ? idx_w(MAX_HOLD) + 1 : 8;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tmo_q, tmo_d;
`endif

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    win_d   = win_q;
    gnt_d   = gnt_q;
    w_rel   = 1'b0;
`ifdef SNOOP_SCHED_TIMEOUT_EN
    tmo_d   = 1'b0;
    cnt_d   = '0;
`endif
    case (state_q)
      IDLE, RELEASE: begin
        gnt_d   = '0;
        state_d = IDLE;
        if (w_pick_any) begin
          state_d = GRANT;
          win_d   = w_pick_idx;
          gnt_d   = w_pick_oh;
        end
      end
      GRANT: begin
        if (bus.busy[win_q]) begin
          state_d = HOLD;
        end else if (!bus.req[win_q]) begin
          w_rel = 1'b1;
        end
      end
      HOLD: begin
        if (!bus.busy[win_q]) begin
          w_rel = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase

`ifdef SNOOP_SCHED_TIMEOUT_EN
    // A natural release in the limit cycle wins and raises no error.
    if (state_q == GRANT || state_q == HOLD) begin
      cnt_d = cnt_q + 1'b1;
      if (!w_rel && cnt_q == CNT_W'(MAX_HOLD - 1)) begin
        w_rel = 1'b1;
        tmo_d = 1'b1;
      end
    end
`endif

    if (w_rel) begin
      state_d = RELEASE;
      gnt_d   = '0;
      last_d  = win_q;
    end
    valid_d = |gnt_d;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      last_q  <= IDW'(NUM_REQ - 1);
      win_q   <= '0;
      gnt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      win_q   <= win_d;
      gnt_q   <= gnt_d;
      valid_q <= valid_d;
    end
  end

`ifdef SNOOP_SCHED_TIMEOUT_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      tmo_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tmo_q <= tmo_d;
    end
  end

  assign bus.timeout_err = tmo_q;
`else
  assign bus.timeout_err = 1'b0;
`endif

  assign bus.gnt       = gnt_q;
  assign bus.gnt_id    = win_q;
  assign bus.gnt_valid = valid_q;

endmodule

`default_nettype wire

// File: doc/snoop_sched.md
# snoop_sched

Round-robin scheduler that shares the single snoop bus among the per-CPU cache controllers. Sits between the caches' bus-request/busy handshakes and the snoop-bus mux select. Issues one one-hot grant at a time and holds it for the whole bus transaction. Rotates priority fairly and optionally recovers from a requester that never releases the bus.

## Interface
- NUM_REQ, default NUM_CPUS: number of requesters.
- MAX_HOLD, default 64: grant-hold limit in cycles; used only with the timeout feature.
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- req  in  NUM_REQ  per-requester bus request, level; held until granted.
- busy  in  NUM_REQ  per-requester transaction-in-progress flag from the granted cache.
- gnt  out  NUM_REQ  one-hot grant; drives the snoop-bus mux select.
- gnt_id  out  $clog2(NUM_REQ)  binary index of the current or last winner.
- gnt_valid  out  1  OR of gnt.
- timeout_err  out  1  one-cycle pulse on forced release; tied 0 when the timeout feature is compiled out.

## Operation
- State machine has four states:
  - IDLE: no grant. Any req set → pick a winner → GRANT.
  - GRANT: gnt[w]=1, waiting for the transaction to start. busy[w]=1 → HOLD. req[w]=0 and busy[w]=0 (withdrawn) → RELEASE. Otherwise stay.
  - HOLD: gnt[w] held. busy[w] falls → RELEASE.
  - RELEASE: gnt=0 for exactly one turnaround cycle; last winner ← w. Any req set → pick a winner → GRANT. Otherwise → IDLE.
- Winner selection: the first set req scanning upward from (last+1) mod NUM_REQ, wrapping. last resets to NUM_REQ-1, so requester 0 wins first after reset.
- Requests and busy bits from non-granted requesters are ignored while a grant is active.
- busy asserted for a non-granted index is ignored.
- gnt is never more than one-hot.
- gnt_id holds its value outside grants.

## Timing
- All outputs are registered.
- Reset values: gnt=0, gnt_id=0, gnt_valid=0, timeout_err=0, state=IDLE, last=NUM_REQ-1, hold counter=0.
- Grant latency: req sampled high in IDLE at edge N → gnt high after edge N+1.
- Release: busy[w] sampled low at edge M → gnt low after M+1 (RELEASE). The next grant appears after M+2.
- Back-to-back throughput is one transaction per (busy length + 2) cycles.
- Simultaneous requests: exactly one grant, decided by rotation. Requester w is not re-granted while any other requester is pending.
- Reset asserted mid-transaction clears gnt immediately, asynchronously. The pending transaction is abandoned, and the caches reset with the same rst.
- A req that deasserts in the same cycle it would be picked is not granted. Selection uses registered-edge samples only.

## Configuration
- SNOOP_SCHED_TIMEOUT_EN defined:
  - An 8-bit-minimum hold counter clears on entry to GRANT and counts every GRANT/HOLD cycle.
  - When the count reaches MAX_HOLD-1 while still GRANT/HOLD, the scheduler forces RELEASE, pulses timeout_err for one cycle (with gnt falling the same edge), and advances last to w.
- SNOOP_SCHED_TIMEOUT_EN undefined:
  - No counter is built, and timeout_err is constant 0.
  - A grant is held indefinitely until busy/req release it.

## Structure
- The shared types package holds:
  - NUM_CPUS (existing).
  - The sched_state_t enum (IDLE, GRANT, HOLD, RELEASE).
  - The SNOOP_SCHED_MAX_HOLD default constant.
- One sub-module, rr_pick: purely combinational rotating priority picker.
  - Inputs: req vector and last index.
  - Outputs: one-hot, index, any.
  - It is reusable by the memory-side port scheduler.

## Test plan
- Single request, NUM_REQ=4: req=4'b0100 at cycle 5, busy[2] high cycles 7-10 → gnt=4'b0100 cycles 6-11, gnt_id=2, gnt low cycle 12.
- All four requesting continuously, busy one cycle each → grant order 0,1,2,3,0. Each grant is separated by a one-cycle gnt=0 gap.
- Withdrawal: grant to 1, then req[1]=0 with busy[1] never set → RELEASE next cycle. Next grant goes to 2 when req[2] is set.
- Reset mid-HOLD: rst low while gnt=4'b1000 → gnt=0 asynchronously. After rst rises with req=4'b1001, the first grant goes to 0.
- Timeout, with the macro defined and MAX_HOLD=16: busy[3] stuck high → gnt drops after 16 cycles of grant, timeout_err pulses once, and the next grant goes to 0. Without the macro, the grant is held for 1000 cycles and timeout_err stays 0.
- Spurious busy: busy[0]=1 while gnt[2] is active → no state change, and the grant releases only on busy[2] falling.
